// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: forwarding selects and stall/flush control for a 5-stage pipeline.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic [REG_AW-1:0] rd_d_i,
    input  logic              valid_d_i,
    input  logic              rs1_used_d_i,
    input  logic              rs2_used_d_i,
    input  logic              regwrite_d_i,
    input  logic              load_d_i,
    input  logic              mul_d_i,
    input  logic              branch_taken_e_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    logic              e_valid, e_regwrite, e_load, e_rs1_used, e_rs2_used;
    logic [REG_AW-1:0] e_rd, e_rs1, e_rs2;
    logic              m_valid, m_regwrite, w_valid, w_regwrite;
    logic [REG_AW-1:0] m_rd, w_rd;
    logic [3:0]        busy_cnt;
    logic              mul_busy, load_use, lu_stall, br_flush, d_take, m_ok, w_ok;

    assign mul_busy = busy_cnt != 4'd0;
    assign load_use = valid_d_i & e_valid & e_load & (e_rd != '0) &
                      ((rs1_used_d_i & (rs1_d_i == e_rd)) | (rs2_used_d_i & (rs2_d_i == e_rd)));
    // A held multiply keeps its E-stage neighbours frozen, so it masks branch and load-use.
    assign br_flush = branch_taken_e_i & ~mul_busy;
    assign lu_stall = load_use & ~branch_taken_e_i & ~mul_busy;

    assign stall_f_o = mul_busy | lu_stall;
    assign stall_d_o = mul_busy | lu_stall;
    assign stall_e_o = mul_busy;
    assign flush_d_o = br_flush;
    assign flush_e_o = br_flush | lu_stall;

    assign m_ok    = m_valid & m_regwrite & (m_rd != '0);
    assign w_ok    = w_valid & w_regwrite & (w_rd != '0);
    assign fwd_a_o = ~e_rs1_used ? 2'b00 : (m_ok & (m_rd == e_rs1)) ? 2'b10 :
                     (w_ok & (w_rd == e_rs1)) ? 2'b01 : 2'b00;
    assign fwd_b_o = ~e_rs2_used ? 2'b00 : (m_ok & (m_rd == e_rs2)) ? 2'b10 :
                     (w_ok & (w_rd == e_rs2)) ? 2'b01 : 2'b00;

    assign d_take = valid_d_i & ~flush_e_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            {e_valid, e_regwrite, e_load, e_rs1_used, e_rs2_used} <= '0;
            {e_rd, e_rs1, e_rs2} <= '0;
            {m_valid, m_regwrite, m_rd} <= '0;
            {w_valid, w_regwrite, w_rd} <= '0;
            busy_cnt <= 4'd0;
        end else begin
            w_valid    <= m_valid;
            w_regwrite <= m_regwrite;
            w_rd       <= m_rd;
            if (mul_busy) begin
                m_valid    <= 1'b0;
                m_regwrite <= 1'b0;
                m_rd       <= '0;
                busy_cnt   <= busy_cnt - 4'd1;
            end else begin
                m_valid    <= e_valid;
                m_regwrite <= e_regwrite;
                m_rd       <= e_rd;
                e_valid    <= d_take;
                e_regwrite <= d_take & regwrite_d_i;
                e_load     <= d_take & load_d_i;
                e_rs1_used <= d_take & rs1_used_d_i;
                e_rs2_used <= d_take & rs2_used_d_i;
                e_rd       <= d_take ? rd_d_i : '0;
                e_rs1      <= d_take ? rs1_d_i : '0;
                e_rs2      <= d_take ? rs2_d_i : '0;
                busy_cnt   <= (d_take & mul_d_i) ? MUL_CNT : 4'd0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_f_o) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_d_o) flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: directed scenarios plus random traffic against an instruction-level model.
module tb_pipeline_hazard_unit;
    localparam int AW = 5, ML = 3, CW = 4;

    typedef struct {
        bit v; bit [4:0] rs1, rs2, rd; bit u1, u2, rw, ld, ml;
    } inst_t;

    logic clk = 1'b0, rst = 1'b1, br = 1'b0;
    always #5 clk = ~clk;

    inst_t d, pipe[3], nop;
    int mul_left, n_stall, n_flush;
    int compared = 0, mismatched = 0;

    logic [1:0] fwd_a_o, fwd_b_o;
    logic stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    pipeline_hazard_unit #(.REG_AW(AW), .MUL_LAT(ML), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d_i(d.rs1), .rs2_d_i(d.rs2), .rd_d_i(d.rd),
        .valid_d_i(d.v), .rs1_used_d_i(d.u1), .rs2_used_d_i(d.u2),
        .regwrite_d_i(d.rw), .load_d_i(d.ld), .mul_d_i(d.ml),
        .branch_taken_e_i(br),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .stall_e_o(stall_e_o),
        .flush_d_o(flush_d_o), .flush_e_o(flush_e_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    task automatic chk(string tag, logic [31:0] obs, int exp);
        compared++;
        assert (obs === 32'(exp)) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Newest producer wins: search M before W; x0 never forwards.
    function automatic int src_sel(bit used, bit [4:0] r);
        if (!used || r == 0) return 0;
        for (int s = 1; s <= 2; s++)
            if (pipe[s].v && pipe[s].rw && pipe[s].rd == r) return 3 - s;
        return 0;
    endfunction

    function automatic int cnt_exp(int n);
`ifdef HAZARD_PERF_CNT_EN
        return n % (1 << CW);
`else
        return 0 * n;
`endif
    endfunction

    task automatic cycle();
        bit busy, lu, sf, fd, fe;
        #1;
        busy = mul_left > 0;
        lu = d.v && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
             ((d.u1 && d.rs1 == pipe[0].rd) || (d.u2 && d.rs2 == pipe[0].rd));
        sf = busy || (lu && !br);
        fd = !busy && br;
        fe = fd || (!busy && lu);
        chk("fwd_a", fwd_a_o, src_sel(pipe[0].u1, pipe[0].rs1));
        chk("fwd_b", fwd_b_o, src_sel(pipe[0].u2, pipe[0].rs2));
        chk("stall_f", stall_f_o, sf);
        chk("stall_d", stall_d_o, sf);
        chk("stall_e", stall_e_o, busy);
        chk("flush_d", flush_d_o, fd);
        chk("flush_e", flush_e_o, fe);
        chk("stall_cnt", stall_cnt_o, cnt_exp(n_stall));
        chk("flush_cnt", flush_cnt_o, cnt_exp(n_flush));
        n_stall += sf ? 1 : 0;
        n_flush += fd ? 1 : 0;
        pipe[2] = pipe[1];
        if (busy) begin
            pipe[1] = nop;
            mul_left--;
        end else begin
            pipe[1] = pipe[0];
            pipe[0] = (d.v && !fe) ? d : nop;
            mul_left = (pipe[0].v && pipe[0].ml) ? ML - 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(bit v, bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd,
                         bit u1, bit u2, bit rw, bit ld, bit ml);
        d = '{v, rs1, rs2, rd, u1, u2, rw, ld, ml};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        br = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        d = nop;
        pipe = '{nop, nop, nop};
        mul_left = 0;
        n_stall = 0;
        n_flush = 0;
        #1;
        chk("rst_fwd_a", fwd_a_o, 0);
        chk("rst_fwd_b", fwd_b_o, 0);
        chk("rst_stall_f", stall_f_o, 0);
        chk("rst_stall_d", stall_d_o, 0);
        chk("rst_stall_e", stall_e_o, 0);
        chk("rst_flush_d", flush_d_o, 0);
        chk("rst_flush_e", flush_e_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
    endtask

    initial begin
        int guard;
        nop = '{default: 0};
        d = nop;
        do_reset();

        // add x5 then sub x6,x5,x2 back to back: forward from M
        set_d(1, 1, 2, 5, 1, 1, 1, 0, 0); cycle();
        set_d(1, 5, 2, 6, 1, 1, 1, 0, 0); cycle();
        d = nop; #1;
        chk("fwd_m", fwd_a_o, 2);
        cycle();
        // one unrelated instruction between: forward from W
        set_d(1, 1, 2, 5, 1, 1, 1, 0, 0); cycle();
        set_d(1, 3, 4, 9, 1, 1, 1, 0, 0); cycle();
        set_d(1, 5, 2, 6, 1, 1, 1, 0, 0); cycle();
        d = nop; #1;
        chk("fwd_w", fwd_a_o, 1);
        cycle();

        // lw x7 then add x8,x7,x1: one bubble, then forward from W
        set_d(1, 1, 0, 7, 1, 0, 1, 1, 0); cycle();
        set_d(1, 7, 1, 8, 1, 1, 1, 0, 0); #1;
        chk("lu_stall_f", stall_f_o, 1);
        chk("lu_stall_d", stall_d_o, 1);
        chk("lu_flush_e", flush_e_o, 1);
        cycle();
        chk("lu_once", stall_f_o, 0);
        cycle();
        d = nop; #1;
        chk("lu_fwd_w", fwd_a_o, 1);
        cycle();

        // multiply holds the front end for MUL_LAT-1 cycles
        set_d(1, 1, 2, 10, 1, 1, 1, 0, 1); cycle();
        d = nop;
        for (int i = 0; i < ML - 1; i++) begin
            #1;
            chk("mul_stall_f", stall_f_o, 1);
            chk("mul_stall_e", stall_e_o, 1);
            cycle();
        end
        chk("mul_done", stall_f_o, 0);
        cycle();

        // branch beats load-use
        set_d(1, 1, 0, 7, 1, 0, 1, 1, 0); cycle();
        set_d(1, 7, 1, 8, 1, 1, 1, 0, 0); br = 1'b1; #1;
        chk("br_flush_d", flush_d_o, 1);
        chk("br_flush_e", flush_e_o, 1);
        chk("br_no_stall", stall_f_o, 0);
        cycle();
        br = 1'b0;

        // x0 is never a hazard
        set_d(1, 1, 2, 0, 1, 1, 1, 0, 0); cycle();
        set_d(1, 0, 0, 3, 1, 1, 1, 0, 0); cycle();
        d = nop; #1;
        chk("x0_fwd", fwd_a_o, 0);
        cycle();
        set_d(1, 1, 0, 0, 1, 0, 1, 1, 0); cycle();
        set_d(1, 0, 0, 4, 1, 1, 1, 0, 0); #1;
        chk("x0_lu", stall_f_o, 0);
        cycle();

        // reset in the middle of a multiply stall
        set_d(1, 1, 2, 11, 1, 1, 1, 0, 1); cycle();
        d = nop; cycle();
        do_reset();
        cycle();

        // 17 stall cycles: one load-use plus multiplies
        do_reset();
        set_d(1, 1, 0, 7, 1, 0, 1, 1, 0); cycle();
        set_d(1, 7, 0, 8, 1, 0, 1, 0, 0); cycle();
        guard = 0;
        while (n_stall < 17 && guard < 100) begin
            set_d(1, 0, 0, 12, 0, 0, 1, 0, 1);
            cycle();
            guard++;
        end
        d = nop; #1;
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cnt_wrap", stall_cnt_o, 1);
`else
        chk("stall_cnt_tied", stall_cnt_o, 0);
`endif
        cycle();

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) do_reset();
            d.v  = $urandom_range(99) < 85;
            d.rs1 = 5'($urandom_range(3));
            d.rs2 = 5'($urandom_range(3));
            d.rd = 5'($urandom_range(3));
            d.u1 = 1'($urandom);
            d.u2 = 1'($urandom);
            d.rw = $urandom_range(99) < 70;
            d.ld = $urandom_range(99) < 30;
            d.ml = $urandom_range(99) < 10;
            br = $urandom_range(99) < 8;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter MUL_LAT, default 3, EX-stage cycles a multiply occupies; legal range 1..15.
REQ-003 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge; rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports rs1_d_i, rs2_d_i, rd_d_i  in  REG_AW  source and destination addresses of the instruction in D.
REQ-006 SHALL have ports valid_d_i, rs1_used_d_i, rs2_used_d_i, regwrite_d_i, load_d_i, mul_d_i  in  1  qualifiers for the instruction in D.
REQ-007 SHALL have port branch_taken_e_i  in  1  redirect resolved by the instruction in E.
REQ-008 SHALL have ports fwd_a_o, fwd_b_o  out  2  EX operand select: 00 register file, 01 W result, 10 M result.
REQ-009 SHALL have ports stall_f_o, stall_d_o, stall_e_o, flush_d_o, flush_e_o  out  1  pipeline-register hold/clear controls.
REQ-010 SHALL have ports stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters (see Configuration).

Function
REQ-011 SHALL keep shadow stages E, M, W, each holding valid, rd, regwrite, load, plus rs1/rs2/used flags in E, advancing on each rising edge under its own stall/flush outputs.
REQ-012 SHALL compute all outputs combinationally from shadow state and current inputs (zero-cycle latency).
REQ-013 SHALL set fwd_a_o=10 when E.rs1_used, M.valid, M.regwrite, M.rd==E.rs1, M.rd!=0; else 01 on the same test against W; else 00; fwd_b_o identically for rs2.
REQ-014 SHALL never forward or detect a hazard on register 0.
REQ-015 SHALL detect load-use when valid_d_i, E.valid, E.load, E.rd!=0 and E.rd matches a used D source; then assert stall_f_o, stall_d_o, flush_e_o for one cycle (bubble into E).
REQ-016 SHALL, when a valid mul enters E, load a busy counter with MUL_LAT-1; while counter>0 assert stall_f_o, stall_d_o, stall_e_o, decrement, and insert a bubble into shadow M; MUL_LAT=1 SHALL cause no stall.
REQ-017 SHALL on branch_taken_e_i assert flush_d_o and flush_e_o, suppress load-use stall that cycle, and override the busy counter only after it reaches 0 (branch in E is held with E).
REQ-018 SHALL give priority: mul-busy > branch flush > load-use stall; never assert stall_x and flush_x on the same stage in one cycle.
REQ-019 SHALL treat valid_d_i=0 as a bubble: no hazard raised, shadow E receives valid=0.
REQ-020 SHALL forward M over W when both match the same source.

Reset
REQ-021 SHALL on rst clear all shadow valid bits, busy counter and counters to 0; all outputs 0 in the cycle following reset.
REQ-022 SHALL let rst override an in-progress mul stall or load-use bubble; no residual stall after release.

Configuration
REQ-023 SHALL compile performance counters only under macro HAZARD_PERF_CNT_EN: stall_cnt_o increments each cycle stall_f_o=1, flush_cnt_o each cycle flush_d_o=1, both wrap at 2^CNT_W.
REQ-024 SHALL without HAZARD_PERF_CNT_EN tie stall_cnt_o and flush_cnt_o to 0 and instantiate no counter flops.

Verification
REQ-025 SHALL cover: add x5 in E, sub using x5 enters E next -> fwd_a_o=10; one cycle later with an unrelated instruction between -> fwd_a_o=01.
REQ-026 SHALL cover: lw x7 in E, add x8,x7,x1 in D -> stall_f_o=stall_d_o=flush_e_o=1 for exactly 1 cycle, then fwd_a_o=01 in E.
REQ-027 SHALL cover: mul in E with MUL_LAT=3 -> stall_f_o/stall_d_o/stall_e_o=1 for exactly 2 cycles, shadow M holds bubbles.
REQ-028 SHALL cover: branch_taken_e_i=1 while load-use is present -> flush_d_o=flush_e_o=1, stall_f_o=0.
REQ-029 SHALL cover: rd=0 writes with matching sources -> fwd 00, no stall; rst asserted mid mul stall -> all outputs 0 next cycle.
REQ-030 SHALL cover with HAZARD_PERF_CNT_EN, CNT_W=4: 17 stall cycles -> stall_cnt_o=1 (wrap).
